// File: rtl/uart_cmd_parser.sv
// Decodes a received "KEY=VALUE" payload, one byte per clock, into key code, magnitude and sign.
// Optional hex values ("0x"/"0X" prefix) are enabled by defining UART_CMD_PARSER_HEX_EN.
module uart_cmd_parser #(
   parameter int unsigned MAX_LEN = 128,
   parameter int unsigned VALUE_W = 32
) (
   input  logic               sys_clk,
   input  logic               sys_rst,
   input  logic [1023:0]      rx_string,
   input  logic [7:0]         rx_length,
   input  logic               rx_done,
   output logic [15:0]        cmd_key,
   output logic [VALUE_W-1:0] cmd_value,
   output logic               cmd_neg,
   output logic               cmd_valid,
   output logic               cmd_err,
   output logic [2:0]         err_code,
   output logic               busy
);

   localparam logic [7:0]         LP_MAX = 8'(MAX_LEN);
   localparam logic [VALUE_W+3:0] LP_TEN = (VALUE_W + 4)'(10);

   typedef enum logic [2:0] {
      StIdle,
      StKey,
      StSign,
      StDigitFirst,
`ifdef UART_CMD_PARSER_HEX_EN
      StHexFirst,
      StHex,
`endif
      StDigit
   } state_t;

   state_t               r_state;
   logic [1023:0]        r_buf;
   logic [7:0]           r_len;
   logic [7:0]           r_idx;
   logic [VALUE_W-1:0]   r_acc;
   logic                 r_neg;
   logic [15:0]          r_key;

   state_t               w_nxt;
   logic [VALUE_W-1:0]   w_acc_nxt;
   logic                 w_neg_nxt;
   logic [15:0]          w_key_nxt;
   logic                 w_fail;
   logic [2:0]           w_code;
   logic                 w_done;
   logic [7:0]           w_byte;
   logic                 w_end;
   logic                 w_last;
   logic                 w_upper;
   logic                 w_is_dig;
   logic [VALUE_W+3:0]   w_dec;

   assign w_byte   = r_buf[{r_idx[6:0], 3'b000} +: 8];
   assign w_end    = (r_idx == r_len);
   assign w_last   = (r_idx == r_len - 8'd1);
   assign w_upper  = (w_byte >= 8'h41) && (w_byte <= 8'h5A);
   assign w_is_dig = (w_byte >= 8'h30) && (w_byte <= 8'h39);
   assign w_dec    = ({4'b0000, r_acc} * LP_TEN) + {{VALUE_W{1'b0}}, w_byte[3:0]};

`ifdef UART_CMD_PARSER_HEX_EN
   logic               r_lead;
   logic               w_lead_nxt;
   logic               w_is_hex;
   logic [3:0]         w_nib;
   logic [VALUE_W+3:0] w_hex;
   logic               w_is_x;

   assign w_is_x   = (w_byte == 8'h78) || (w_byte == 8'h58);
   assign w_is_hex = w_is_dig || ((w_byte >= 8'h41) && (w_byte <= 8'h46))
                     || ((w_byte >= 8'h61) && (w_byte <= 8'h66));
   assign w_nib    = w_is_dig ? w_byte[3:0] : (w_byte[3:0] + 4'd9);
   assign w_hex    = {r_acc, 4'b0000} + {{VALUE_W{1'b0}}, w_nib};
`endif

   always_comb begin
      w_nxt     = r_state;
      w_acc_nxt = r_acc;
      w_neg_nxt = r_neg;
      w_key_nxt = r_key;
      w_fail    = 1'b0;
      w_code    = 3'd0;
`ifdef UART_CMD_PARSER_HEX_EN
      w_lead_nxt = 1'b0;
`endif
      case (r_state)
         StKey: begin
            if (w_end) begin
               w_fail = 1'b1;
               w_code = 3'd3;
            end else if (r_idx == 8'd0) begin
               if (w_upper) begin
                  w_key_nxt = {8'h00, w_byte};
               end else begin
                  w_fail = 1'b1;
                  w_code = 3'd2;
               end
            end else if ((r_idx == 8'd1) && w_upper) begin
               w_key_nxt = {r_key[7:0], w_byte};
            end else if (w_byte == 8'h3D) begin
               w_nxt = StSign;
            end else begin
               w_fail = 1'b1;
               w_code = 3'd3;
            end
         end
         StSign, StDigitFirst: begin
            if (!w_end && (r_state == StSign) && (w_byte == 8'h2D)) begin
               w_neg_nxt = 1'b1;
               w_nxt     = StDigitFirst;
            end else if (!w_end && w_is_dig) begin
               w_acc_nxt = {{(VALUE_W - 4){1'b0}}, w_byte[3:0]};
               w_nxt     = StDigit;
`ifdef UART_CMD_PARSER_HEX_EN
               w_lead_nxt = (w_byte == 8'h30);
`endif
            end else begin
               w_fail = 1'b1;
               w_code = 3'd4;
            end
         end
         StDigit: begin
            if (!w_end && w_is_dig) begin
               if (w_dec[VALUE_W+3:VALUE_W] != 4'd0) begin
                  w_fail = 1'b1;
                  w_code = 3'd5;
               end else begin
                  w_acc_nxt = w_dec[VALUE_W-1:0];
               end
`ifdef UART_CMD_PARSER_HEX_EN
            end else if (!w_end && r_lead && w_is_x) begin
               w_nxt = StHexFirst;
`endif
            end else begin
               w_fail = 1'b1;
               w_code = 3'd4;
            end
         end
`ifdef UART_CMD_PARSER_HEX_EN
         StHexFirst, StHex: begin
            if (!w_end && w_is_hex) begin
               if (w_hex[VALUE_W+3:VALUE_W] != 4'd0) begin
                  w_fail = 1'b1;
                  w_code = 3'd5;
               end else begin
                  w_acc_nxt = w_hex[VALUE_W-1:0];
                  w_nxt     = StHex;
               end
            end else begin
               w_fail = 1'b1;
               w_code = 3'd4;
            end
         end
`endif
         default: ;
      endcase
   end

`ifdef UART_CMD_PARSER_HEX_EN
   assign w_done = !w_fail && w_last && ((w_nxt == StDigit) || (w_nxt == StHex));
`else
   assign w_done = !w_fail && w_last && (w_nxt == StDigit);
`endif

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_state   <= StIdle;
         r_buf     <= '0;
         r_len     <= '0;
         r_idx     <= '0;
         r_acc     <= '0;
         r_neg     <= 1'b0;
         r_key     <= '0;
         cmd_key   <= '0;
         cmd_value <= '0;
         cmd_neg   <= 1'b0;
         cmd_valid <= 1'b0;
         cmd_err   <= 1'b0;
         err_code  <= '0;
         busy      <= 1'b0;
`ifdef UART_CMD_PARSER_HEX_EN
         r_lead    <= 1'b0;
`endif
      end else begin
         cmd_valid <= 1'b0;
         cmd_err   <= 1'b0;
         if (r_state == StIdle) begin
            if (rx_done) begin
               if ((rx_length == 8'd0) || (rx_length > LP_MAX)) begin
                  cmd_err  <= 1'b1;
                  err_code <= 3'd1;
               end else begin
                  r_buf   <= rx_string;
                  r_len   <= rx_length;
                  r_idx   <= '0;
                  r_acc   <= '0;
                  r_neg   <= 1'b0;
                  r_key   <= '0;
                  r_state <= StKey;
                  busy    <= 1'b1;
               end
            end
         end else begin
            r_idx <= r_idx + 8'd1;
            r_acc <= w_acc_nxt;
            r_neg <= w_neg_nxt;
            r_key <= w_key_nxt;
`ifdef UART_CMD_PARSER_HEX_EN
            r_lead <= w_lead_nxt;
`endif
            if (w_fail) begin
               cmd_err  <= 1'b1;
               err_code <= w_code;
               r_state  <= StIdle;
               busy     <= 1'b0;
            end else if (w_done) begin
               cmd_key   <= w_key_nxt;
               cmd_value <= w_acc_nxt;
               cmd_neg   <= w_neg_nxt;
               cmd_valid <= 1'b1;
               r_state   <= StIdle;
               busy      <= 1'b0;
            end else begin
               r_state <= w_nxt;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: latency, decoded fields, error codes, overlap and reset.
// Hex-mode expectations follow UART_CMD_PARSER_HEX_EN.
module tb_uart_cmd_parser;

   logic          sys_clk = 1'b0;
   logic          sys_rst = 1'b1;
   logic [1023:0] rx_string = '0;
   logic [7:0]    rx_length = '0;
   logic          rx_done = 1'b0;
   logic [15:0]   cmd_key;
   logic [31:0]   cmd_value;
   logic          cmd_neg;
   logic          cmd_valid;
   logic          cmd_err;
   logic [2:0]    err_code;
   logic          busy;

   int n_pass  = 0;
   int n_total = 0;
   int lat;
   int pulses;
   logic got_v, got_e;
   logic [31:0] seen_val;

   uart_cmd_parser #(.MAX_LEN(128), .VALUE_W(32)) dut (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .rx_string(rx_string),
      .rx_length(rx_length),
      .rx_done  (rx_done),
      .cmd_key  (cmd_key),
      .cmd_value(cmd_value),
      .cmd_neg  (cmd_neg),
      .cmd_valid(cmd_valid),
      .cmd_err  (cmd_err),
      .err_code (err_code),
      .busy     (busy)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic load(input string s, input int ln);
      logic [1023:0] v;
      v = '0;
      for (int i = 0; i < s.len(); i++) v[8*i +: 8] = s[i];
      rx_string = v;
      rx_length = ln[7:0];
   endtask

   // Pulse rx_done, then count negedges until a result pulse is seen.
   task automatic run(input string s, input int ln);
      load(s, ln);
      rx_done = 1'b1;
      @(negedge sys_clk);
      rx_done = 1'b0;
      lat = 0;
      while (!cmd_valid && !cmd_err && lat < 300) begin
         @(negedge sys_clk);
         lat++;
      end
      got_v = cmd_valid;
      got_e = cmd_err;
      if (lat >= 300) check("timeout", 64'(lat), 64'd0);
   endtask

   initial begin
      repeat (3) @(negedge sys_clk);
      check("rst_key", 64'(cmd_key), 64'h0);
      check("rst_val", 64'(cmd_value), 64'h0);
      check("rst_flags", 64'({cmd_neg, cmd_valid, cmd_err, busy}), 64'h0);
      check("rst_code", 64'(err_code), 64'h0);
      sys_rst = 1'b0;
      @(negedge sys_clk);

      run("F=1000", 6);
      check("f1000_valid", 64'({got_v, got_e}), 64'b10);
      check("f1000_lat", 64'(lat), 64'd6);
      check("f1000_key", 64'(cmd_key), 64'h0046);
      check("f1000_val", 64'(cmd_value), 64'd1000);
      check("f1000_neg", 64'(cmd_neg), 64'd0);
      check("f1000_busy", 64'(busy), 64'd0);
      @(negedge sys_clk);
      check("f1000_pulse1", 64'(cmd_valid), 64'd0);

      run("AM=-25", 6);
      check("am_valid", 64'({got_v, got_e}), 64'b10);
      check("am_lat", 64'(lat), 64'd6);
      check("am_key", 64'(cmd_key), 64'h414D);
      check("am_val", 64'(cmd_value), 64'd25);
      check("am_neg", 64'(cmd_neg), 64'd1);

      run("F1000", 5);
      check("nokeq_err", 64'({got_v, got_e}), 64'b01);
      check("nokeq_code", 64'(err_code), 64'd3);
      check("nokeq_lat", 64'(lat), 64'd2);
      check("nokeq_key_held", 64'(cmd_key), 64'h414D);
      check("nokeq_val_held", 64'(cmd_value), 64'd25);

      run("F=4294967296", 12);
      check("ovf_err", 64'({got_v, got_e}), 64'b01);
      check("ovf_code", 64'(err_code), 64'd5);
      check("ovf_lat", 64'(lat), 64'd12);

      run("F=4294967295", 12);
      check("max_valid", 64'({got_v, got_e}), 64'b10);
      check("max_val", 64'(cmd_value), 64'hFFFFFFFF);
      check("max_neg", 64'(cmd_neg), 64'd0);

      run("", 0);
      check("len0_err", 64'({got_v, got_e}), 64'b01);
      check("len0_lat", 64'(lat), 64'd0);
      check("len0_code", 64'(err_code), 64'd1);

      run("F=1", 200);
      check("len200_code", 64'({got_e, err_code}), 64'h9);
      check("len200_lat", 64'(lat), 64'd0);

      run("F=", 2);
      check("empty_val", 64'({got_e, err_code}), 64'hC);
      check("empty_lat", 64'(lat), 64'd3);

      run("f=1", 3);
      check("lower_key", 64'({got_e, err_code}), 64'hA);
      check("lower_lat", 64'(lat), 64'd1);

      run("F=-", 3);
      check("sign_only", 64'({got_e, err_code}), 64'hC);
      check("sign_only_lat", 64'(lat), 64'd4);

      run("F=1a", 4);
      check("trailing", 64'({got_e, err_code}), 64'hC);

      run("ABC=1", 5);
      check("key3", 64'({got_e, err_code}), 64'hB);
      check("key3_lat", 64'(lat), 64'd3);

      run("F=0", 3);
      check("zero_valid", 64'({got_v, got_e}), 64'b10);
      check("zero_val", 64'(cmd_value), 64'd0);
      check("code_held", 64'(err_code), 64'd3);

`ifdef UART_CMD_PARSER_HEX_EN
      run("F=0x1F", 6);
      check("hex_valid", 64'({got_v, got_e}), 64'b10);
      check("hex_val", 64'(cmd_value), 64'd31);
      run("F=-0XaB", 7);
      check("hexneg_val", 64'({cmd_neg, cmd_value}), 64'h1_0000_00AB);
      run("F=0x", 4);
      check("hex_empty", 64'({got_e, err_code}), 64'hC);
      check("hex_empty_lat", 64'(lat), 64'd5);
`else
      run("F=0x1F", 6);
      check("nohex_err", 64'({got_e, err_code}), 64'hC);
      check("nohex_lat", 64'(lat), 64'd4);
`endif

      // A second rx_done while busy must not disturb the parse in flight.
      load("F=123", 5);
      rx_done = 1'b1;
      @(negedge sys_clk);
      rx_done = 1'b0;
      pulses = 0;
      seen_val = '0;
      for (int c = 1; c <= 14; c++) begin
         @(negedge sys_clk);
         if (c == 2) begin
            load("G=9", 3);
            rx_done = 1'b1;
         end else begin
            rx_done = 1'b0;
         end
         if (cmd_valid || cmd_err) begin
            pulses++;
            seen_val = cmd_value;
         end
      end
      check("overlap_pulses", 64'(pulses), 64'd1);
      check("overlap_val", 64'(seen_val), 64'd123);
      check("overlap_key", 64'(cmd_key), 64'h0046);

      load("AM=-77", 6);
      rx_done = 1'b1;
      @(negedge sys_clk);
      rx_done = 1'b0;
      repeat (2) @(negedge sys_clk);
      sys_rst = 1'b1;
      #1;
      check("midrst_key", 64'(cmd_key), 64'h0);
      check("midrst_val", 64'(cmd_value), 64'h0);
      check("midrst_flags", 64'({cmd_neg, cmd_valid, cmd_err, busy, err_code}), 64'h0);
      @(negedge sys_clk);
      sys_rst = 1'b0;
      pulses = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge sys_clk);
         if (cmd_valid || cmd_err || busy) pulses++;
      end
      check("midrst_quiet", 64'(pulses), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Downstream consumer of the UART string receive handler.
- On each completed receive (rx_done), walks the received payload one byte per clock and decodes a "KEY=VALUE" command into a key code and a binary value.
- Emits a one-cycle cmd_valid or cmd_err pulse to the register/control layer that drives DDS, ADC and measurement blocks.

Parameters:
- MAX_LEN, 128, maximum accepted payload length in bytes (1..128).
- VALUE_W, 32, width of the decoded magnitude.

Ports:
- sys_clk  input  1  system clock; all logic on rising edge.
- sys_rst  input  1  asynchronous, active-high reset.
- rx_string  input  1024  payload; byte k occupies bits [8k+7:8k].
- rx_length  input  8  payload byte count; valid when rx_done is high.
- rx_done  input  1  one-cycle pulse: rx_string/rx_length valid.
- cmd_key  output  16  key; 1-char key = {8'h00, c0}, 2-char key = {c0, c1}.
- cmd_value  output  VALUE_W  decoded magnitude.
- cmd_neg  output  1  '-' sign present.
- cmd_valid  output  1  one-cycle pulse: cmd_key/cmd_value/cmd_neg updated.
- cmd_err  output  1  one-cycle pulse: parse failed.
- err_code  output  3  reason for the last cmd_err; held until the next cmd_err.
- busy  output  1  high while not IDLE.

Behaviour:
- Reset: all outputs 0; state IDLE; internal string buffer, index and accumulator cleared.
- Grammar: 1-2 chars A-Z, then '=', then optional '-', then 1+ chars 0-9; nothing after the digits.
- Length check, in IDLE when rx_done is sampled (edge T0):
  - rx_length==0 or rx_length>MAX_LEN: cmd_err=1 at T0, err_code=1, remain IDLE.
  - Otherwise: latch rx_string and rx_length, idx=0, acc=0, enter KEY.
- rx_done while busy is ignored; the in-flight parse is unaffected.
- One byte (byte idx of the latched buffer) is consumed per edge; idx increments by 1 per edge.
- States:
  - KEY:
    - idx 0 must be A-Z, else err 2.
    - idx 1 A-Z: second key char, stay in KEY.
    - idx 1 '=': go SIGN.
    - Byte at idx 2 must be '=' (go SIGN), else err 3.
    - Any other byte at idx 1 is err 3.
  - SIGN:
    - '-': set neg, go DIGIT_FIRST.
    - Digit: acc=digit, go DIGIT.
    - Else err 4.
  - DIGIT_FIRST: digit → acc=digit, go DIGIT; else err 4.
  - DIGIT:
    - Digit → acc = acc*10 + digit.
    - Multiply uses a VALUE_W+4 bit intermediate.
    - If the result is ≥ 2^VALUE_W: err 5.
  - Any non-digit in DIGIT: err 4.
- Buffer end: reaching idx==length while still in KEY, SIGN or DIGIT_FIRST is err 3/4/4 respectively, detected on the edge after the last byte.
- Success: when the last byte is consumed in DIGIT without error, on that same edge:
  - cmd_key, cmd_value and cmd_neg are updated;
  - cmd_valid=1 for one cycle;
  - return to IDLE.
- Latency: cmd_valid is high in the cycle following edge T(L), where L=rx_length.
- Error handling: on any error, cmd_err=1 for one cycle, err_code is set, return to IDLE on the detecting edge. cmd_key/cmd_value/cmd_neg hold their previous values.
- A new rx_done is accepted in the IDLE cycle immediately after a result.
- cmd_valid and cmd_err are never high together.
- busy is high from the edge after the T0 accept until the result edge.
- Asynchronous reset mid-parse: immediately returns to IDLE with all outputs 0; no pulse is emitted.

Optional Feature:
- Macro: UART_CMD_PARSER_HEX_EN.
- When defined:
  - After '=' or '-', the prefix "0x" or "0X" switches to hex mode.
  - Hex mode accepts 0-9, A-F, a-f with acc = (acc<<4) + nibble.
  - Overflow rule is unchanged (err 5).
  - The prefix with no following hex digit is err 4.
- When undefined: 'x' is a non-digit and gives err 4; no hex logic is synthesised.

Test Plan:
- "F=1000", L=6 → cmd_valid exactly 6 cycles after the rx_done edge; cmd_key=16'h0046, cmd_value=1000, cmd_neg=0, busy low afterwards.
- "AM=-25", L=6 → cmd_key=16'h414D, cmd_value=25, cmd_neg=1; then "F1000" → cmd_err, err_code=3, cmd_key still 16'h414D.
- "F=4294967296" → cmd_err, err_code=5. "F=4294967295" → cmd_valid, cmd_value=32'hFFFFFFFF.
- rx_length=0 → cmd_err at T0, err_code=1. "F=" → err_code=4. "f=1" → err_code=2.
- Second rx_done pulse 2 cycles into the parse of "F=123" → exactly one cmd_valid (value 123). Assert sys_rst mid-parse → no pulse, all outputs 0.
- With UART_CMD_PARSER_HEX_EN: "F=0x1F" → cmd_value=31. "F=0x" → err_code=4. Without the macro, "F=0x1F" → err_code=4.
